mux4way16_rr: RTL and testbench
===============================

MUX4WAY16_RR -- requirements
Module: mux4way16_rr

Interface
REQ-001 SHALL have no parameters; all data paths are 16 bits.
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: a, b, c, d  input  16 each  source channel data, channel index 0..3 respectively.
REQ-005 SHALL have port: valid  input  4  per-channel request, bit i = channel i (0=a, 3=d).
REQ-006 SHALL have port: ready  output  4  per-channel accept, bit i = channel i.
REQ-007 SHALL have port: out  output  16  merged data, registered.
REQ-008 SHALL have port: sel  output  2  source index of the word in out, registered.
REQ-009 SHALL have port: out_valid  output  1  out/sel hold an unconsumed word.
REQ-010 SHALL have port: out_ready  input  1  downstream accept.
REQ-011 SHALL have port: count  output  16  total accepted transfers, registered.

Function
REQ-012 SHALL contain a single-entry output register holding out, sel and out_valid.
REQ-013 SHALL define an input transfer on channel i as valid[i] && ready[i] at a rising edge.
REQ-014 SHALL define an output transfer as out_valid && out_ready at a rising edge.
REQ-015 SHALL consider the register free in a cycle when out_valid=0 or out_ready=1.
REQ-016 SHALL drive ready combinationally: ready is all-zero when the register is not free or valid=0.
REQ-017 SHALL otherwise drive exactly one ready bit high: the first requesting channel found scanning from the priority pointer upward, modulo 4.
REQ-018 SHALL hold a 2-bit priority pointer; after a grant to channel g, the pointer becomes (g+1) mod 4.
REQ-019 SHALL leave the pointer unchanged in any cycle with no input transfer.
REQ-020 SHALL load out with the granted channel's data, sel with g, and set out_valid=1 on the edge of an input transfer, giving one-cycle latency.
REQ-021 SHALL, on simultaneous output and input transfer, replace the register contents at full throughput of one word per cycle with no bubble.
REQ-022 SHALL clear out_valid on an output transfer with no input transfer, leaving out and sel at their last values.
REQ-023 SHALL hold out, sel and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL increment count by 1 per input transfer, wrapping 0xFFFF to 0x0000.
REQ-025 SHALL never accept more than one channel per cycle.
REQ-026 SHALL not drop or duplicate any accepted word.

Reset
REQ-027 SHALL, while reset=1 (asynchronously, independent of clk), force out=0x0000, sel=2'b00, out_valid=0, count=0x0000, pointer=0 (channel a highest) and ready=4'b0000.
REQ-028 SHALL discard any word in flight when reset asserts mid-operation.
REQ-029 SHALL begin arbitration on the first rising edge after reset deasserts.

Verification
REQ-030 Single source: after reset, valid=4'b0010, b=0x0001, out_ready=1 for one cycle -> ready=4'b0010 that cycle; next cycle out=0x0001, sel=01, out_valid=1, count=1.
REQ-031 Round-robin: valid=4'b1111 held with a..d=0x000A/0x000B/0x000C/0x000D, out_ready=1 -> sel sequence 00,01,10,11,00 on consecutive cycles, out tracking the matching data, count +1 per cycle.
REQ-032 Backpressure: register full, out_ready=0 for 3 cycles with valid=4'b1111 -> ready=4'b0000, out/sel/count frozen; out_ready back to 1 -> transfers resume at the channel after the last grant.
REQ-033 Drain: single word in register, valid=0, out_ready=1 -> out_valid=0 next cycle, out keeps the last value.
REQ-034 Reset mid-stream: reset pulse during REQ-031 traffic -> out=0x0000, sel=00, out_valid=0, count=0 immediately; first grant after release goes to channel a.
REQ-035 Wrap: 65536 accepted transfers from reset -> count=0x0000.

Source files
------------

// File: rtl/mux4way16_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux4way16_rr
// Description : Four-channel, 16-bit round-robin merge onto one registered
//               output stage with valid/ready handshaking on every port and
//               a running count of accepted words.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4way16_rr (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [3:0]  valid,
    output logic [3:0]  ready,
    output logic [15:0] out,
    output logic [1:0]  sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] count
);

    // Channel index that currently holds the highest priority.
    logic [1:0]  r_ptr;

    // Output register contents and the transfer counter.
    logic [15:0] r_out;
    logic [1:0]  r_sel;
    logic        r_out_valid;
    logic [15:0] r_count;

    // Arbitration results for the current cycle.
    logic        w_found;
    logic [1:0]  w_gidx;
    logic [1:0]  w_scan;
    logic        w_free;
    logic        w_accept;
    logic [15:0] w_gdata;

    // The register can take a new word if it is empty or is being drained
    // this very cycle, which gives one word per cycle with no bubble.
    assign w_free = !r_out_valid || out_ready;

    // Scan the requests starting at the pointer and wrapping past channel 3.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = 2'b00;
        w_scan  = 2'b00;
        for (int k = 0; k < 4; k++) begin
            w_scan = r_ptr + k[1:0];
            if (!w_found && valid[w_scan]) begin
                w_found = 1'b1;
                w_gidx  = w_scan;
            end
        end
    end

    // Reset gates the grant so that ready reads all-zero while reset is held,
    // even though the register looks free at that point.
    assign w_accept = w_found && w_free && !reset;

    // One-hot accept towards the granted source; at most one bit is ever set.
    always_comb begin
        ready = 4'b0000;
        if (w_accept) begin
            ready = 4'b0001 << w_gidx;
        end
    end

    // Select the data word of the granted channel.
    always_comb begin
        w_gdata = a;
        case (w_gidx)
            2'd0:    w_gdata = a;
            2'd1:    w_gdata = b;
            2'd2:    w_gdata = c;
            default: w_gdata = d;
        endcase
    end

    // Output stage, pointer and counter; a grant always wins over a drain
    // so a simultaneous input and output transfer simply replaces the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= 2'b00;
            r_out       <= 16'h0000;
            r_sel       <= 2'b00;
            r_out_valid <= 1'b0;
            r_count     <= 16'h0000;
        end else if (w_accept) begin
            r_ptr       <= w_gidx + 2'd1;
            r_out       <= w_gdata;
            r_sel       <= w_gidx;
            r_out_valid <= 1'b1;
            r_count     <= r_count + 16'd1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign sel       = r_sel;
    assign out_valid = r_out_valid;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mux4way16_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4way16_rr
// Description : Self-checking bench for mux4way16_rr: a behavioural model
//               compared against the DUT every cycle, plus literal anchors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4way16_rr;

    logic        clk;
    logic        reset;
    logic [15:0] a, b, c, d;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [15:0] out;
    logic [1:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_ptr;
    int m_out;
    int m_sel;
    int m_ov;
    int m_count;

    mux4way16_rr dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .valid     (valid),
        .ready     (ready),
        .out       (out),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which channel the rules grant this cycle, -1 if none.
    function automatic int m_grant();
        if (reset) return -1;
        if (m_ov != 0 && !out_ready) return -1;
        for (int i = 0; i < 4; i++) begin
            int ch;
            ch = (m_ptr + i) % 4;
            if (valid[ch]) return ch;
        end
        return -1;
    endfunction

    function automatic int m_data(input int ch);
        case (ch)
            0: return int'(a);
            1: return int'(b);
            2: return int'(c);
            default: return int'(d);
        endcase
    endfunction

    // Model update on the clock edge (inputs change only after the edge).
    always @(posedge clk or posedge reset) begin
        int g;
        if (reset) begin
            m_ptr = 0; m_out = 0; m_sel = 0; m_ov = 0; m_count = 0;
        end else begin
            g = m_grant();
            if (g >= 0) begin
                m_out   = m_data(g);
                m_sel   = g;
                m_ov    = 1;
                m_ptr   = (g + 1) % 4;
                m_count = (m_count + 1) % 65536;
            end else if (out_ready) begin
                m_ov = 0;
            end
        end
    end

    // Compare process: mid-cycle, every cycle.
    always @(negedge clk) begin
        int g;
        logic [3:0] er;
        g  = m_grant();
        er = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("ready", {12'h000, ready}, {12'h000, er});
        chk("out", out, 16'(m_out));
        chk("sel", {14'h0, sel}, 16'(m_sel));
        chk("out_valid", {15'h0, out_valid}, 16'(m_ov));
        chk("count", count, 16'(m_count));
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; valid = 4'b0000; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; c = 16'h0; d = 16'h0;
        #1;
        // Reset forces everything idle, even with every request raised.
        reset = 1'b1; valid = 4'b1111; out_ready = 1'b1;
        #1;
        chk("rst_ready", {12'h0, ready}, 16'h0000);
        chk("rst_out", out, 16'h0000);
        chk("rst_valid", {15'h0, out_valid}, 16'h0000);
        chk("rst_count", count, 16'h0000);
        next_cycle();
        next_cycle();

        // Single source on channel b.
        reset = 1'b0; valid = 4'b0010; b = 16'h0001; out_ready = 1'b1;
        #2;
        chk("single_ready", {12'h0, ready}, 16'h0002);
        next_cycle();
        valid = 4'b0000;
        chk("single_out", out, 16'h0001);
        chk("single_sel", {14'h0, sel}, 16'h0001);
        chk("single_valid", {15'h0, out_valid}, 16'h0001);
        chk("single_count", count, 16'h0001);

        // Round-robin with all channels requesting.
        reset = 1'b1; #1; reset = 1'b0;
        a = 16'h000A; b = 16'h000B; c = 16'h000C; d = 16'h000D;
        valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            chk("rr_sel", {14'h0, sel}, 16'(k % 4));
            chk("rr_out", out, 16'(16'h000A + (k % 4)));
            chk("rr_count", count, 16'(k + 1));
        end

        // Backpressure: register full, downstream stalled.
        out_ready = 1'b0;
        #1;
        chk("bp_ready", {12'h0, ready}, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            chk("bp_out", out, 16'h000A);
            chk("bp_sel", {14'h0, sel}, 16'h0000);
            chk("bp_count", count, 16'h0005);
        end
        out_ready = 1'b1;
        next_cycle();
        chk("bp_resume_sel", {14'h0, sel}, 16'h0001);
        chk("bp_resume_count", count, 16'h0006);

        // Drain: no requests, downstream accepts.
        valid = 4'b0000;
        next_cycle();
        chk("drain_valid", {15'h0, out_valid}, 16'h0000);
        chk("drain_out", out, 16'h000B);

        // Reset in the middle of streaming traffic.
        valid = 4'b1111;
        next_cycle();
        next_cycle();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out", out, 16'h0000);
        chk("midrst_sel", {14'h0, sel}, 16'h0000);
        chk("midrst_valid", {15'h0, out_valid}, 16'h0000);
        chk("midrst_count", count, 16'h0000);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        chk("midrst_first_sel", {14'h0, sel}, 16'h0000);
        chk("midrst_first_out", out, 16'h000A);

        // Randomised traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            a = 16'($urandom); b = 16'($urandom);
            c = 16'($urandom); d = 16'($urandom);
            valid = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            next_cycle();
        end

        // Counter wrap after 65536 transfers from reset.
        reset = 1'b1; #1; reset = 1'b0;
        valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 65535; k++) next_cycle();
        chk("wrap_pre", count, 16'hFFFF);
        next_cycle();
        chk("wrap", count, 16'h0000);

        valid = 4'b0000;
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
